sar_logic_param: RTL and testbench
==================================

Name: sar_logic_param

Overview:
- Parametrised successor SAR controller for the SAR ADC macro.
- Drives the capacitive DAC (ctlp/ctln), sample switch and comparator clock enable.
- Performs an NBITS binary search per conversion, plus an optional comparator-offset calibration that majority-votes CAL_ITER comparisons per trim bit.
- New over the fixed 8-bit version: generic widths, continuous-conversion mode, a held result with valid/ack handshake, and a trim-load override.

Parameters:
- NBITS, 8: conversion resolution; width of result, ctlp and ctln.
- TRIM_BITS, 5: comparator trim DAC width.
- CAL_ITER, 7: comparisons per trim bit during calibration; odd, 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start request; sampled in WAIT.
- cal  in  1  with en: run calibration instead of a conversion.
- cont  in  1  continuous mode: restart conversion without waiting for en.
- comp  in  1  comparator decision, valid at posedge.
- ack  in  1  consumer accepts result; clears valid.
- trim_ld  in  1  load trim_in into the trim register (WAIT only).
- trim_in  in  TRIM_BITS  external trim value.
- valid  out  1  result held and unacknowledged.
- result  out  NBITS  last conversion code.
- sample  out  1  sample switch closed.
- ctlp  out  NBITS  result | mask.
- ctln  out  NBITS  ~(result | mask).
- trim  out  TRIM_BITS  trim_val | trim_mask.
- trimb  out  TRIM_BITS  ~trim.
- clkc_en  out  1  comparator clock enable, registered; gating cell is external.
- busy  out  1  state is not WAIT.
- cal_done  out  1  one-cycle pulse when calibration completes.

Behaviour:
- Reset (clk edge with rst=1) has priority over everything and aborts any operation:
  - state=INIT, mask=0, trim_mask=0, result=0, trim_val=0.
  - valid=0, clkc_en=0, cal_count=CAL_ITER, cal_itt=0.
  - Outputs therefore reset to: ctlp=0, ctln=all-ones, trim=0, trimb=all-ones, sample=0, busy=1.
- INIT: trim_val <= 1<<(TRIM_BITS-1) (mid-scale); next state WAIT.
- WAIT:
  - If trim_ld: trim_val <= trim_in; stay in WAIT. trim_ld beats en in the same cycle.
  - Else if en or (cont and not cal): result<=0, calibrate<=cal, mask<=1<<(NBITS-1), clkc_en<=1, go to SAMPLE.
  - trim_ld outside WAIT is ignored.
- SAMPLE, one cycle:
  - If calibrate: trim_val<=0, trim_mask<=1<<(TRIM_BITS-1), cal_itt<=0, cal_count<=CAL_ITER, go to CAL.
  - Else go to CONV.
- CONV, exactly NBITS cycles:
  - Each cycle: if comp, result<=result|mask; then mask<=mask>>1.
  - On the cycle with mask[0]=1: go to DONE, clkc_en<=0, and register result into the output holding register.
- CAL, per trim bit, CAL_ITER vote cycles plus one decision cycle:
  - Vote cycle: cal_count decrements on comp=1 and increments on comp=0; cal_itt increments.
  - Decision cycle (cal_itt==CAL_ITER):
    - If cal_count>CAL_ITER, set trim_val|=trim_mask.
    - trim_mask>>=1; cal_count<=CAL_ITER; cal_itt<=0.
    - If trim_mask[0] was set: go to DONE, clkc_en<=0, calibrate<=0, pulse cal_done.
  - Total CAL time: TRIM_BITS*(CAL_ITER+1) cycles. cal_count width is clog2(2*CAL_ITER+1).
- DONE, one cycle:
  - After a conversion, valid<=1. After calibration, valid is unchanged and result is unchanged.
  - Next state WAIT.
- Handshake:
  - valid holds until a cycle with ack=1 clears it.
  - If a new conversion finishes while valid=1, result is overwritten and valid stays 1 (overrun; no stall).
  - ack and a new result on the same cycle: valid=1 (new result wins).
- Continuous mode: with cont=1, WAIT→SAMPLE is immediate, so the conversion period is NBITS+3 cycles.
- Combinational outputs:
  - sample = SAMPLE or CAL.
  - ctlp, ctln, trim, trimb follow the equations in Ports.
  - busy = state≠WAIT.
- Latency: en accepted at edge 0 → valid high after edge NBITS+2.
- Unused state encodings → WAIT on the next edge.

Decomposition:
- Shared package sar_pkg:
  - State enum: S_INIT, S_WAIT, S_SAMPLE, S_CONV, S_DONE, S_CAL.
  - Helper function for cal_count width.
  - Mid-scale trim constant function.
- One natural sub-module: sar_cal_vote (up/down vote counter with cal_itt, decision flag and reset-to-CAL_ITER); reused by the future multi-channel SAR.

Test Plan (NBITS=8, TRIM_BITS=5, CAL_ITER=7):
- Reset then idle → after 2 edges: state WAIT, trim=5'b10000, ctln=8'hFF, valid=0, busy=0.
- en pulse, comp driven from target code 8'hA5 compared against ctlp → valid after edge 10, result=8'hA5, clkc_en high for exactly 9 cycles.
- cal=1 with en, comp=0 always → 40 CAL cycles, trim=5'b11111, cal_done single pulse, valid unchanged.
- cal=1 with en, comp=1 always → trim=5'b00000; a subsequent trim_ld with trim_in=5'h0C → trim=5'h0C.
- cont=1 with no ack, codes 8'h01 then 8'hFE → period 11 cycles, valid stays 1, result=8'hFE; ack on a later idle cycle → valid=0.
- rst asserted mid-CONV (mask=8'h08) → next edge: state INIT, ctlp=0, clkc_en=0, valid=0, then trim=5'b10000.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR controller family.
// Imported by the controller top and the calibration vote counter.
package sar_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_WAIT   = 3'd1,
        S_SAMPLE = 3'd2,
        S_CONV   = 3'd3,
        S_DONE   = 3'd4,
        S_CAL    = 3'd5
    } sar_state_e;

    // Vote counter spans 0..2*iter around a mid-point of iter.
    function automatic int cal_cnt_w(input int iter);
        return $clog2(2 * iter + 1);
    endfunction

    function automatic int cal_itt_w(input int iter);
        return $clog2(iter + 1);
    endfunction

    function automatic int trim_mid(input int bits);
        return 1 << (bits - 1);
    endfunction

endpackage

// File: rtl/sar_cal_vote.sv
// Up/down majority vote counter for one comparator trim bit.
// decide flags the cycle after CAL_ITER votes; above is the majority.
module sar_cal_vote
    import sar_pkg::*;
#(
    parameter int CAL_ITER = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    input  logic comp,
    output logic decide,
    output logic above
);

    localparam int CW = cal_cnt_w(CAL_ITER);
    localparam int IW = cal_itt_w(CAL_ITER);
    localparam logic [CW-1:0] CNT_MID = CW'(CAL_ITER);
    localparam logic [IW-1:0] ITT_END = IW'(CAL_ITER);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] itt_q, itt_d;

    assign decide = (itt_q == ITT_END);
    assign above  = (cnt_q > CNT_MID);

    always_comb begin
        cnt_d = cnt_q;
        itt_d = itt_q;
        if (clr || (step && decide)) begin
            cnt_d = CNT_MID;
            itt_d = '0;
        end else if (step) begin
            itt_d = itt_q + 1'b1;
            cnt_d = comp ? cnt_q - 1'b1 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_MID;
            itt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            itt_q <= itt_d;
        end
    end

endmodule

// File: rtl/sar_logic_param.sv
// Parametrised SAR controller: binary search conversion, comparator
// offset calibration, held result with valid/ack and trim override.
module sar_logic_param
    import sar_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int TRIM_BITS = 5,
    parameter int CAL_ITER  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cal,
    input  logic                 cont,
    input  logic                 comp,
    input  logic                 ack,
    input  logic                 trim_ld,
    input  logic [TRIM_BITS-1:0] trim_in,
    output logic                 valid,
    output logic [NBITS-1:0]     result,
    output logic                 sample,
    output logic [NBITS-1:0]     ctlp,
    output logic [NBITS-1:0]     ctln,
    output logic [TRIM_BITS-1:0] trim,
    output logic [TRIM_BITS-1:0] trimb,
    output logic                 clkc_en,
    output logic                 busy,
    output logic                 cal_done
);

    localparam logic [TRIM_BITS-1:0] TRIM_MID = TRIM_BITS'(trim_mid(TRIM_BITS));
    localparam logic [NBITS-1:0]     MASK_MSB = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_e state_q, state_d;

    logic [NBITS-1:0]     mask_q, mask_d;
    logic [NBITS-1:0]     res_q, res_d;
    logic [NBITS-1:0]     result_q, result_d;
    logic [TRIM_BITS-1:0] trim_val_q, trim_val_d;
    logic [TRIM_BITS-1:0] trim_mask_q, trim_mask_d;
    logic                 valid_q, valid_d;
    logic                 clkc_en_q, clkc_en_d;
    logic                 calibrate_q, calibrate_d;
    logic                 cal_done_q, cal_done_d;

    logic start;
    logic vote_clr;
    logic vote_step;
    logic decide;
    logic above;

    assign start = (state_q == S_WAIT) && !trim_ld
                   && (en || (cont && !cal));
    assign vote_clr  = (state_q == S_SAMPLE) && calibrate_q;
    assign vote_step = (state_q == S_CAL);

    sar_cal_vote #(
        .CAL_ITER (CAL_ITER)
    ) u_vote (
        .clk    (clk),
        .rst    (rst),
        .clr    (vote_clr),
        .step   (vote_step),
        .comp   (comp),
        .decide (decide),
        .above  (above)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_WAIT;
        case (state_q)
            S_INIT:   state_d = S_WAIT;
            S_WAIT:   state_d = start ? S_SAMPLE : S_WAIT;
            S_SAMPLE: state_d = calibrate_q ? S_CAL : S_CONV;
            S_CONV:   state_d = mask_q[0] ? S_DONE : S_CONV;
            S_CAL:    state_d = (decide && trim_mask_q[0]) ? S_DONE : S_CAL;
            S_DONE:   state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        sample = (state_q == S_SAMPLE) || (state_q == S_CAL);
        busy   = (state_q != S_WAIT);
    end

    assign ctlp     = res_q | mask_q;
    assign ctln     = ~(res_q | mask_q);
    assign trim     = trim_val_q | trim_mask_q;
    assign trimb    = ~trim;
    assign valid    = valid_q;
    assign result   = result_q;
    assign clkc_en  = clkc_en_q;
    assign cal_done = cal_done_q;

    always_comb begin
        mask_d      = mask_q;
        res_d       = res_q;
        result_d    = result_q;
        trim_val_d  = trim_val_q;
        trim_mask_d = trim_mask_q;
        valid_d     = valid_q & ~ack;
        clkc_en_d   = clkc_en_q;
        calibrate_d = calibrate_q;
        cal_done_d  = 1'b0;
        case (state_q)
            S_INIT: trim_val_d = TRIM_MID;
            S_WAIT: begin
                if (trim_ld) begin
                    trim_val_d = trim_in;
                end else if (start) begin
                    res_d       = '0;
                    calibrate_d = cal;
                    mask_d      = MASK_MSB;
                    clkc_en_d   = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (calibrate_q) begin
                    trim_val_d  = '0;
                    trim_mask_d = TRIM_MID;
                end
            end
            S_CONV: begin
                if (comp) res_d = res_q | mask_q;
                mask_d = mask_q >> 1;
                if (mask_q[0]) begin
                    clkc_en_d = 1'b0;
                    result_d  = res_d;
                end
            end
            S_CAL: begin
                if (decide) begin
                    if (above) trim_val_d = trim_val_q | trim_mask_q;
                    trim_mask_d = trim_mask_q >> 1;
                    if (trim_mask_q[0]) begin
                        clkc_en_d   = 1'b0;
                        calibrate_d = 1'b0;
                        cal_done_d  = 1'b1;
                    end
                end
            end
            // A new result beats a same-cycle ack; calibration leaves valid alone.
            S_DONE: if (!cal_done_q) valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            res_q       <= '0;
            result_q    <= '0;
            trim_val_q  <= '0;
            trim_mask_q <= '0;
            valid_q     <= 1'b0;
            clkc_en_q   <= 1'b0;
            calibrate_q <= 1'b0;
            cal_done_q  <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            res_q       <= res_d;
            result_q    <= result_d;
            trim_val_q  <= trim_val_d;
            trim_mask_q <= trim_mask_d;
            valid_q     <= valid_d;
            clkc_en_q   <= clkc_en_d;
            calibrate_q <= calibrate_d;
            cal_done_q  <= cal_done_d;
        end
    end

endmodule

// File: tb/tb_sar_logic_param.sv
// Directed self-checking bench for sar_logic_param (8/5/7 configuration).
// Comparator is modelled from a target code or forced to a constant.
module tb_sar_logic_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cal = 1'b0;
    logic       cont = 1'b0;
    logic       ack = 1'b0;
    logic       trim_ld = 1'b0;
    logic [4:0] trim_in = '0;
    logic       comp;
    logic       valid;
    logic [7:0] result;
    logic       sample;
    logic [7:0] ctlp;
    logic [7:0] ctln;
    logic [4:0] trim;
    logic [4:0] trimb;
    logic       clkc_en;
    logic       busy;
    logic       cal_done;

    logic       use_tgt = 1'b1;
    logic [7:0] target = '0;
    logic       comp_const = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign comp = use_tgt ? (ctlp <= target) : comp_const;

    sar_logic_param #(
        .NBITS     (8),
        .TRIM_BITS (5),
        .CAL_ITER  (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cal      (cal),
        .cont     (cont),
        .comp     (comp),
        .ack      (ack),
        .trim_ld  (trim_ld),
        .trim_in  (trim_in),
        .valid    (valid),
        .result   (result),
        .sample   (sample),
        .ctlp     (ctlp),
        .ctln     (ctln),
        .trim     (trim),
        .trimb    (trimb),
        .clkc_en  (clkc_en),
        .busy     (busy),
        .cal_done (cal_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int vedge;
        int pc;
        int e1;
        int e2;

        // reset and idle
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1);
        chk("rst_ctlp", ctlp, 8'h00);
        chk("rst_ctln", ctln, 8'hFF);
        chk("rst_trim", trim, 5'h00);
        chk("rst_trimb", trimb, 5'h1F);
        chk("rst_valid", valid, 0);
        chk("rst_clkc", clkc_en, 0);
        chk("rst_sample", sample, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_trim", trim, 5'b10000);
        chk("idle_ctln", ctln, 8'hFF);
        chk("idle_valid", valid, 0);

        // single conversion of 0xA5
        use_tgt = 1'b1;
        target  = 8'hA5;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("conv_sample", sample, 1);
        cnt   = clkc_en ? 1 : 0;
        vedge = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (clkc_en) cnt++;
            if (valid && vedge == 0) vedge = i;
        end
        chk("conv_clkc_cycles", cnt, 9);
        chk("conv_valid_edge", vedge, 10);
        chk("conv_result", result, 8'hA5);
        chk("conv_ctlp", ctlp, 8'hA5);
        chk("conv_busy", busy, 0);

        // calibration, comparator always low
        use_tgt    = 1'b0;
        comp_const = 1'b0;
        en  = 1'b1;
        cal = 1'b1;
        tick();
        en  = 1'b0;
        cal = 1'b0;
        cnt = sample ? 1 : 0;
        pc  = cal_done ? 1 : 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (sample) cnt++;
            if (cal_done) pc++;
        end
        chk("cal0_sample_cycles", cnt, 41);
        chk("cal0_done_pulses", pc, 1);
        chk("cal0_trim", trim, 5'b11111);
        chk("cal0_trimb", trimb, 5'b00000);
        chk("cal0_valid", valid, 1);
        chk("cal0_result", result, 8'hA5);
        chk("cal0_busy", busy, 0);

        // calibration, comparator always high
        comp_const = 1'b1;
        en  = 1'b1;
        cal = 1'b1;
        tick();
        en  = 1'b0;
        cal = 1'b0;
        for (int i = 1; i <= 45; i++) tick();
        chk("cal1_trim", trim, 5'b00000);
        chk("cal1_busy", busy, 0);

        // trim load wins over en
        trim_ld = 1'b1;
        trim_in = 5'h0C;
        en      = 1'b1;
        tick();
        trim_ld = 1'b0;
        en      = 1'b0;
        chk("trimld_trim", trim, 5'h0C);
        chk("trimld_busy", busy, 0);

        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_valid", valid, 0);

        // continuous mode, overrun without ack
        use_tgt = 1'b1;
        target  = 8'h01;
        cont    = 1'b1;
        tick();
        e1 = -1;
        e2 = -1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 10) begin
                chk("cont_valid_first", valid, 1);
                chk("cont_busy_gap", busy, 0);
                target = 8'hFE;
            end
            if (i == 11) begin
                chk("cont_restart", busy, 1);
                cont = 1'b0;
            end
            if (result == 8'h01 && e1 < 0) e1 = i;
            if (result == 8'hFE && e2 < 0) e2 = i;
        end
        chk("cont_first_edge", e1, 9);
        chk("cont_second_edge", e2, 20);
        chk("cont_valid_overrun", valid, 1);
        chk("cont_result", result, 8'hFE);
        chk("cont_idle", busy, 0);
        tick();
        tick();
        chk("cont_valid_held", valid, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("cont_ack_valid", valid, 0);

        // reset in the middle of a conversion
        target = 8'h3C;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 1; i <= 11; i++) tick();
        chk("c3c_valid", valid, 1);
        chk("c3c_result", result, 8'h3C);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        chk("mid_ctlp", ctlp, 8'h38);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1);
        chk("abort_ctlp", ctlp, 8'h00);
        chk("abort_clkc", clkc_en, 0);
        chk("abort_valid", valid, 0);
        chk("abort_trim", trim, 5'h00);
        tick();
        chk("abort_trim_mid", trim, 5'b10000);
        chk("abort_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
